// File: rtl/xadc_vga_bargraph_if.sv
// rtl/xadc_vga_bargraph_if.sv - channel sample bus from the XADC DRP read logic
interface xadc_vga_bargraph_if;
  logic       sample_valid;
  logic [1:0] sample_chan;
  logic [7:0] sample_data;

  modport master (output sample_valid, sample_chan, sample_data);
  modport slave  (input  sample_valid, sample_chan, sample_data);
endinterface

// File: rtl/xadc_vga_bargraph.sv
// rtl/xadc_vga_bargraph.sv - four-channel XADC bar graph on 640x480@60 VGA
module xadc_vga_bargraph #(
  parameter int PIX_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  xadc_vga_bargraph_if.slave    smp,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  frame_start
);
  localparam int PW = $clog2(PIX_DIV);
  localparam logic [PW-1:0] PDIV_MAX = PW'(PIX_DIV - 1);

  logic [PW-1:0] pdiv;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic [7:0]    sh [4];
  logic [7:0]    fr [4];
  logic          pe;

  logic [1:0]    slot;
  logic [9:0]    xoff;
  logic [7:0]    height;
  logic [8:0]    rise;
  logic          active;
  logic          in_bar;
  logic          lit;
  logic          hs_n;
  logic          vs_n;
  logic [11:0]   rgb;

  assign pe          = (pdiv == PDIV_MAX);
  assign frame_start = pe && (hcnt == 10'd0) && (vcnt == 10'd480);

  always_comb begin
    slot = 2'd3;
    xoff = hcnt - 10'd480;
    if (hcnt < 10'd160) begin
      slot = 2'd0;
      xoff = hcnt;
    end else if (hcnt < 10'd320) begin
      slot = 2'd1;
      xoff = hcnt - 10'd160;
    end else if (hcnt < 10'd480) begin
      slot = 2'd2;
      xoff = hcnt - 10'd320;
    end
    height = fr[slot];
    // rise is only used when vcnt <= 447, so the subtraction never wraps
    rise   = 9'd447 - vcnt[8:0];
    active = (hcnt < 10'd640) && (vcnt < 10'd480);
    in_bar = (xoff >= 10'd16) && (xoff <= 10'd143);
    lit    = in_bar && (vcnt <= 10'd447) && (rise < {1'b0, height});
    rgb    = 12'h000;
    if (active) begin
      if (vcnt == 10'd448) begin
        rgb = 12'h888;
      end else if (lit) begin
        case (slot)
          2'd0:    rgb = 12'hF00;
          2'd1:    rgb = 12'h0F0;
          2'd2:    rgb = 12'h00F;
          default: rgb = 12'hFFF;
        endcase
      end
    end
    hs_n = !((hcnt >= 10'd656) && (hcnt <= 10'd751));
    vs_n = !((vcnt >= 10'd490) && (vcnt <= 10'd491));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pdiv   <= '0;
      hcnt   <= '0;
      vcnt   <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        sh[i] <= 8'h00;
        fr[i] <= 8'h00;
      end
    end else begin
      pdiv <= pe ? '0 : pdiv + PW'(1);
      if (pe) begin
        // syncs and colour share one register stage so they stay aligned
        vga_hs                <= hs_n;
        vga_vs                <= vs_n;
        {vga_r, vga_g, vga_b} <= rgb;
        if (hcnt == 10'd799) begin
          hcnt <= '0;
          vcnt <= (vcnt == 10'd524) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
      if (frame_start) begin
        for (int i = 0; i < 4; i++) fr[i] <= sh[i];
      end
      if (smp.sample_valid) sh[smp.sample_chan] <= smp.sample_data;
    end
  end
endmodule

// File: tb/tb_xadc_vga_bargraph.sv
// tb/tb_xadc_vga_bargraph.sv - scoreboard bench for xadc_vga_bargraph
module tb_xadc_vga_bargraph;
  localparam int PD      = 2;
  localparam int FRAME   = 420000;
  localparam int LATCH_N = 480 * 800;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       hs, vs, frame_start;
  logic [3:0] r, g, b;

  xadc_vga_bargraph_if smp();

  xadc_vga_bargraph #(.PIX_DIV(PD)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .smp         (smp),
    .vga_hs      (hs),
    .vga_vs      (vs),
    .vga_r       (r),
    .vga_g       (g),
    .vga_b       (b),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   sh_m [4];
  int   fr_m [4];
  pix_t exp_q [$];
  pix_t cur;
  bit   started = 0;
  bit   in_rst = 1;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic pix_t ref_pixel(int h, int v);
    pix_t p;
    int   k, off;
    p.hs = !(h >= 656 && h <= 751);
    p.vs = !(v >= 490 && v <= 491);
    p.r = 4'h0; p.g = 4'h0; p.b = 4'h0;
    if (h < 640 && v < 480) begin
      k   = h / 160;
      off = h % 160;
      if (v == 448) begin
        p.r = 4'h8; p.g = 4'h8; p.b = 4'h8;
      end else if (off >= 16 && off <= 143 && v <= 447 && (447 - v) < fr_m[k]) begin
        p.r = (k == 0 || k == 3) ? 4'hF : 4'h0;
        p.g = (k == 1 || k == 3) ? 4'hF : 4'h0;
        p.b = (k == 2 || k == 3) ? 4'hF : 4'h0;
      end
    end
    return p;
  endfunction

  // Reference model: pixel n is registered on clk edge PD*(n+1) after release
  always @(posedge clk) begin : model
    int n, h, v;
    started = 1;
    if (!rstn) begin
      in_rst = 1;
      cyc = 0;
      for (int i = 0; i < 4; i++) begin sh_m[i] = 0; fr_m[i] = 0; end
      exp_q.delete();
      exp_q.push_back(pix_t'{hs: 1'b1, vs: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0});
    end else begin
      in_rst = 0;
      cyc++;
      if (cyc % PD == 0) begin
        n = cyc / PD - 1;
        h = n % 800;
        v = (n / 800) % 525;
        exp_q.push_back(ref_pixel(h, v));
        if (n % FRAME == LATCH_N) for (int i = 0; i < 4; i++) fr_m[i] = sh_m[i];
      end
      if (smp.sample_valid) sh_m[int'(smp.sample_chan)] = int'(smp.sample_data);
    end
  end

  always @(negedge clk) begin : monitor
    logic want_fs;
    if (started) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      n_cmp++;
      if ({hs, vs, r, g, b} !== cur) begin
        n_bad++;
        if (n_bad <= 50)
          $display("FAIL pixel cyc=%0d got hs/vs/rgb=%b/%b/%h%h%h want %b/%b/%h%h%h",
                   cyc, hs, vs, r, g, b, cur.hs, cur.vs, cur.r, cur.g, cur.b);
      end
      want_fs = !in_rst && ((cyc + 1) % PD == 0) && ((((cyc + 1) / PD) - 1) % FRAME == LATCH_N);
      n_cmp++;
      if (frame_start !== want_fs) begin
        n_bad++;
        if (n_bad <= 50)
          $display("FAIL frame_start cyc=%0d got=%b want=%b", cyc, frame_start, want_fs);
      end
    end
  end

  function automatic int pix_edge(int f, int h, int v);
    return PD * (f * FRAME + v * 800 + h + 1);
  endfunction

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int ch, input int d);
    smp.sample_valid = 1'b1;
    smp.sample_chan  = ch[1:0];
    smp.sample_data  = d[7:0];
  endtask

  task automatic send(input int e, input int ch, input int d);
    wait_edge(e - 1);
    drive(ch, d);
    @(posedge clk);
    #1;
    smp.sample_valid = 1'b0;
  endtask

  initial begin : watchdog
    #40000000;
    $display("FAIL watchdog cyc=%0d expired before end of stimulus", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    smp.sample_valid = 1'b0;
    smp.sample_chan  = 2'd0;
    smp.sample_data  = 8'd0;
    rstn = 1'b0;
    repeat (10) @(posedge clk);
    #1 rstn = 1'b1;

    // frame 0: random traffic, then known values written late enough to win
    for (int i = 0; i < 20; i++)
      send(pix_edge(0, $urandom_range(0, 799), 10 + i * 20),
           $urandom_range(0, 3), $urandom_range(0, 255));
    wait_edge(pix_edge(0, 100, 472) - 1);
    drive(0, 10);  @(posedge clk); #1;
    drive(0, 200); @(posedge clk); #1;
    drive(0, 30);  @(posedge clk); #1;
    smp.sample_valid = 1'b0;
    send(pix_edge(0, 100, 473), 1, 100);
    send(pix_edge(0, 100, 474), 3, 255);
    send(pix_edge(0, 100, 475), 2, 20);
    // lands on the latch edge: frame 1 keeps 20, frame 2 shows 50
    send(pix_edge(0, 0, 480), 2, 50);

    // frame 1: random heights on ch1, ch0 goes to zero
    for (int i = 0; i < 15; i++)
      send(pix_edge(1, $urandom_range(0, 799), 20 + i * 25), 1, $urandom_range(0, 255));
    send(pix_edge(1, 50, 475), 0, 0);

    // frame 2: show bars, then reset mid-frame and watch timing restart
    wait_edge(pix_edge(2, 300, 470) - 1);
    rstn = 1'b0;
    repeat (5) @(posedge clk);
    #1 rstn = 1'b1;
    wait_edge(pix_edge(0, 0, 3));
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
